wb_vmon_byte_master: RTL and testbench

//  Upstream feeder for the Wishbone vmon monitor. Accepts a byte stream (valid/ready),

---
 rtl/wb_vmon_byte_master.sv | 141 ++++++++++++++
 tb/tb_wb_vmon_byte_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_vmon_byte_master.sv
// rtl/wb_vmon_byte_master.sv - byte stream to Wishbone single-write packer for the vmon monitor
// Packs up to four bytes per write; three-byte packets split into a 0011 beat then a 0001 beat.
module wb_vmon_byte_master #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = '0,
  parameter int                       FLUSH_TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               s_dat,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [WB_ADDR_WIDTH-1:0] ADR,
  output logic [WB_DATA_WIDTH-1:0] DAT_W,
  output logic [3:0]               SEL,
  output logic                     CYC,
  output logic                     STB,
  output logic                     WE,
  input  logic                     ACK,
  input  logic                     ERR,
  output logic                     busy_o,
  output logic                     err_o
);

  if (WB_DATA_WIDTH != 32) begin : g_bad_width
    $error("wb_vmon_byte_master: only WB_DATA_WIDTH=32 is supported");
  end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_vmon_byte_master: FLUSH_TIMEOUT must be >= 1");
  end

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, WR, WR2} state_t;

  state_t                   state_q;
  logic [2:0]               cnt_q;
  logic [3:0][7:0]          buf_q;
  logic [TW-1:0]            tmr_q;
  logic                     s_ready_q;
  logic                     cyc_q;
  logic                     err_q;
  logic                     split_q;
  logic [WB_DATA_WIDTH-1:0] dat_q;
  logic [3:0]               sel_q;

  logic            accept;
  logic            flush;
  logic            done;
  logic [2:0]      cnt_d;
  logic [3:0][7:0] buf_d;

  always_comb begin
    accept = s_valid && s_ready_q && (state_q == FILL);
    cnt_d  = cnt_q + {2'b00, accept};
    buf_d  = buf_q;
    if (accept) buf_d[cnt_q[1:0]] = s_dat;
    // Timer expiry only flushes on a cycle that brought no new byte.
    flush = (state_q == FILL) &&
            ((accept && (cnt_d == 3'd4 || s_last)) ||
             (!accept && cnt_q != 3'd0 && tmr_q == TW'(FLUSH_TIMEOUT - 1)));
    done  = (state_q == WR || state_q == WR2) && (ACK || ERR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      buf_q     <= '0;
      tmr_q     <= '0;
      s_ready_q <= 1'b0;
      cyc_q     <= 1'b0;
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      dat_q     <= '0;
      sel_q     <= '0;
    end else begin
      err_q <= done && ERR;
      case (state_q)
        FILL: begin
          cnt_q     <= cnt_d;
          buf_q     <= buf_d;
          tmr_q     <= (accept || cnt_q == 3'd0) ? '0 : tmr_q + TW'(1);
          s_ready_q <= !flush;
          if (flush) begin
            state_q <= WR;
            cyc_q   <= 1'b1;
            split_q <= (cnt_d == 3'd3);
            case (cnt_d)
              3'd4: begin
                sel_q <= 4'b1111;
                dat_q <= buf_d;
              end
              3'd3, 3'd2: begin
                sel_q <= 4'b0011;
                dat_q <= {16'h0000, buf_d[1], buf_d[0]};
              end
              default: begin
                sel_q <= 4'b0001;
                dat_q <= {24'h000000, buf_d[0]};
              end
            endcase
          end
        end
        WR, WR2: begin
          s_ready_q <= 1'b0;
          if (done) begin
            if (state_q == WR && split_q) begin
              // Second beat of a 3-byte packet keeps CYC asserted across the boundary.
              state_q <= WR2;
              split_q <= 1'b0;
              sel_q   <= 4'b0001;
              dat_q   <= {24'h000000, buf_q[2]};
            end else begin
              state_q <= FILL;
              cyc_q   <= 1'b0;
              cnt_q   <= '0;
              tmr_q   <= '0;
              sel_q   <= '0;
              dat_q   <= '0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign ADR     = ADDRESS;
  assign DAT_W   = dat_q;
  assign SEL     = sel_q;
  assign CYC     = cyc_q;
  assign STB     = cyc_q;
  assign WE      = cyc_q;
  assign busy_o  = (cnt_q != 3'd0) || cyc_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_wb_vmon_byte_master.sv
// tb/tb_wb_vmon_byte_master.sv - directed self-checking bench for wb_vmon_byte_master
module tb_wb_vmon_byte_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  s_dat;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] ADR;
  logic [31:0] DAT_W;
  logic [3:0]  SEL;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic        ACK;
  logic        ERR;
  logic        busy_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  wb_vmon_byte_master #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .ADDRESS      (32'h0000_0000),
    .FLUSH_TIMEOUT(16)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .s_dat  (s_dat),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .ADR    (ADR),
    .DAT_W  (DAT_W),
    .SEL    (SEL),
    .CYC    (CYC),
    .STB    (STB),
    .WE     (WE),
    .ACK    (ACK),
    .ERR    (ERR),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_dat   = b;
    s_last  = last;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("send_ready_wait", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk_i);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic ack_beat(input string tag);
    ACK = 1'b1;
    @(negedge clk_i);
    ACK = 1'b0;
    chk({tag, "_cyc_drop"}, CYC, 0);
  endtask

  initial begin
    int k;
    rst_i = 1'b1; s_dat = 8'h00; s_valid = 1'b0; s_last = 1'b0; ACK = 1'b0; ERR = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", CYC, 0);
    chk("rst_stb", STB, 0);
    chk("rst_we", WE, 0);
    chk("rst_sel", SEL, 0);
    chk("rst_dat", DAT_W, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", s_ready, 1);
    chk("adr", ADR, 32'h0000_0000);

    // full word, single-cycle ACK, latency
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    chk("t1_stb_n1", STB, 1);
    chk("t1_we", WE, 1);
    chk("t1_sel", SEL, 4'b1111);
    chk("t1_dat", DAT_W, 32'h44332211);
    chk("t1_ready_wr", s_ready, 0);
    chk("t1_busy", busy_o, 1);
    ack_beat("t1");
    chk("t1_ready_n2", s_ready, 0);
    @(negedge clk_i);
    chk("t1_ready_n3", s_ready, 1);
    chk("t1_busy_idle", busy_o, 0);

    // two-byte and three-byte packets
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    chk("t2_sel2", SEL, 4'b0011);
    chk("t2_dat2", DAT_W, 32'h0000BBAA);
    ack_beat("t2a");
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b1);
    chk("t2_sel3a", SEL, 4'b0011);
    chk("t2_dat3a", DAT_W, 32'h0000C2C1);
    ACK = 1'b1;
    @(negedge clk_i);
    chk("t2_stb3b", STB, 1);
    chk("t2_cyc3b", CYC, 1);
    chk("t2_sel3b", SEL, 4'b0001);
    chk("t2_dat3b", DAT_W, 32'h000000C3);
    @(negedge clk_i);
    ACK = 1'b0;
    chk("t2_cyc_end", CYC, 0);
    chk("t2_busy_end", busy_o, 1'b0);

    // flush timeout
    send(8'h5A, 1'b0);
    k = 1;
    while (STB !== 1'b1 && k < 40) begin @(negedge clk_i); k++; end
    chk("t3_timeout_lat", k, 17);
    chk("t3_sel", SEL, 4'b0001);
    chk("t3_dat", DAT_W, 32'h0000005A);
    ack_beat("t3a");
    send(8'h5B, 1'b0);
    repeat (14) @(negedge clk_i);
    chk("t3_no_early_stb", STB, 0);
    send(8'h6C, 1'b0);
    k = 1;
    while (STB !== 1'b1 && k < 40) begin @(negedge clk_i); k++; end
    chk("t3_restart_lat", k, 17);
    chk("t3_restart_sel", SEL, 4'b0011);
    chk("t3_restart_dat", DAT_W, 32'h00006C5B);
    ack_beat("t3b");

    // wait states, then ERR
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_stb", STB, 1);
      chk("t4_hold_sel", SEL, 4'b1111);
      chk("t4_hold_dat", DAT_W, 32'h40302010);
      chk("t4_hold_ready", s_ready, 0);
      @(negedge clk_i);
    end
    ack_beat("t4a");
    send(8'hE1, 1'b1);
    ERR = 1'b1;
    @(negedge clk_i);
    ERR = 1'b0;
    chk("t4_err_cyc", CYC, 0);
    chk("t4_err_pulse", err_o, 1);
    @(negedge clk_i);
    chk("t4_err_once", err_o, 0);
    send(8'h71, 1'b0); send(8'h72, 1'b0); send(8'h73, 1'b1);
    ERR = 1'b1;
    @(negedge clk_i);
    ERR = 1'b0;
    chk("t4_split_err_pulse", err_o, 1);
    chk("t4_split_second_stb", STB, 1);
    chk("t4_split_second_dat", DAT_W, 32'h00000073);
    ack_beat("t4b");
    chk("t4_split_err_clear", err_o, 0);
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b0);
    chk("t4_after_err_dat", DAT_W, 32'h0D0C0B0A);
    ack_beat("t4c");
    chk("t4_after_err_noerr", err_o, 0);

    // reset during a split
    send(8'h91, 1'b0); send(8'h92, 1'b0); send(8'h93, 1'b1);
    chk("t5_stb_before_rst", STB, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t5_cyc_rst", CYC, 0);
    chk("t5_busy_rst", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t5_no_second_beat", STB, 0);
    end
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("t5_sel", SEL, 4'b1111);
    chk("t5_dat", DAT_W, 32'h04030201);
    ack_beat("t5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
